// File: rtl/ps2_hex_pkg.sv
// Shared constants and types for the PS/2 hex readout.
//   PS2_EXT / PS2_BRK : PS/2 extended and break prefix bytes
//   SEG_*             : active-low seven-segment patterns (bit 0 = segment a)
//   key_state_t       : prefix decoder state
package ps2_hex_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_0     = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_state_t;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
//   nibble : value 0..F
//   seg    : segments, bit 0 = a ... bit 6 = g, 0 = lit
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/ps2_hex_display.sv
// Seven-segment readout of PS/2 keyboard bytes.
//   CLOCK_50   : system clock, all state on rising edge
//   reset      : synchronous, active-high
//   byte_data  : received PS/2 byte, qualified by byte_valid
//   byte_valid : one-cycle strobe
//   mode       : 0 = RAW byte history, 1 = KEY (current make code)
//   clear      : synchronous clear of history and key state
//   hex_out    : 2*NUM_BYTES active-low digits, digit i at [7i+6:7i], digit 0 rightmost
//   key_down   : a make code is currently held (KEY mode)
//   last_make  : last accepted make code
//   extended   : last_make was E0-prefixed
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 then F0 seen
module ps2_hex_display
  import ps2_hex_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [7:0]                byte_data,
  input  logic                      byte_valid,
  input  logic                      mode,
  input  logic                      clear,
  output logic [14*NUM_BYTES-1:0]   hex_out,
  output logic                      key_down,
  output logic [7:0]                last_make,
  output logic                      extended
);

  logic [NUM_BYTES-1:0][7:0] slot_q, slot_d;
  logic [NUM_BYTES-1:0]      slot_vld_q, slot_vld_d;
  key_state_t                state_q, state_d;
  logic                      key_down_q, key_down_d;
  logic [7:0]                last_make_q, last_make_d;
  logic                      extended_q, extended_d;
  logic                      mode_q;
  logic                      flush;

  // A mode flip wipes everything so neither view inherits stale state.
  assign flush = clear | (mode != mode_q);

  always_comb begin
    slot_d      = slot_q;
    slot_vld_d  = slot_vld_q;
    state_d     = state_q;
    key_down_d  = key_down_q;
    last_make_d = last_make_q;
    extended_d  = extended_q;
    if (flush) begin
      slot_d      = '0;
      slot_vld_d  = '0;
      state_d     = ST_IDLE;
      key_down_d  = 1'b0;
      last_make_d = 8'h00;
      extended_d  = 1'b0;
    end else if (byte_valid && !mode) begin
      slot_d     = {slot_q[NUM_BYTES-2:0], byte_data};
      slot_vld_d = {slot_vld_q[NUM_BYTES-2:0], 1'b1};
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_data == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (byte_data == PS2_BRK) begin
            state_d = ST_BRK;
          end else begin
            last_make_d = byte_data;
            extended_d  = 1'b0;
            key_down_d  = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_data == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (byte_data != PS2_EXT) begin
            last_make_d = byte_data;
            extended_d  = 1'b1;
            key_down_d  = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // Releases of a key other than the one displayed are ignored.
          if (byte_data == last_make_q && (state_q == ST_EXT_BRK) == extended_q)
            key_down_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      slot_q      <= '0;
      slot_vld_q  <= '0;
      state_q     <= ST_IDLE;
      key_down_q  <= 1'b0;
      last_make_q <= 8'h00;
      extended_q  <= 1'b0;
      mode_q      <= mode;
    end else begin
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      last_make_q <= last_make_d;
      extended_q  <= extended_d;
      mode_q      <= mode;
    end
  end

  assign key_down  = key_down_q;
  assign last_make = last_make_q;
  assign extended  = extended_q;

  for (genvar i = 0; i < 2*NUM_BYTES; i++) begin : g_dig
    logic [3:0] raw_nib;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [6:0] raw_seg;
    logic [6:0] key_seg;

    assign raw_nib = slot_q[i/2][(i%2)*4 +: 4];
    if (i < 2) begin : g_key_lo
      assign nib     = mode_q ? last_make_q[(i%2)*4 +: 4] : raw_nib;
      assign key_seg = key_down_q ? seg : SEG_BLANK;
    end else if (i < 4) begin : g_key_pfx
      assign nib     = raw_nib;
      assign key_seg = (key_down_q && extended_q) ? ((i == 3) ? SEG_E : SEG_0) : SEG_BLANK;
    end else begin : g_key_off
      assign nib     = raw_nib;
      assign key_seg = SEG_BLANK;
    end

    hex7seg u_hex7seg (
      .nibble (nib),
      .seg    (seg)
    );

    assign raw_seg         = slot_vld_q[i/2] ? seg : SEG_BLANK;
    assign hex_out[7*i +: 7] = mode_q ? key_seg : raw_seg;
  end

endmodule

// File: tb/tb_ps2_hex_display.sv
module tb_ps2_hex_display;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            mode;
  logic            clear;
  logic [14*NB-1:0] hex_out;
  logic            key_down;
  logic [7:0]      last_make;
  logic            extended;

  int checks = 0;
  int errors = 0;

  ps2_hex_display #(.NUM_BYTES(NB)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .mode       (mode),
    .clear      (clear),
    .hex_out    (hex_out),
    .key_down   (key_down),
    .last_make  (last_make),
    .extended   (extended)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit        r;
    bit        m;
    bit        c;
    bit        v;
    bit [7:0]  d;
    bit [31:0] nib;   // expected digit values, digit i at [4i+3:4i]
    bit [7:0]  blk;   // 1 = digit expected blank
    bit        kd;
    bit        ext;
    bit [7:0]  lm;
    string     name;
  } vec_t;

  typedef struct {
    bit [14*NB-1:0] hex;
    bit             kd;
    bit             ext;
    bit [7:0]       lm;
    string          name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic bit [6:0] glyph(input bit [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit [14*NB-1:0] exp_hex(input bit [31:0] nib, input bit [7:0] blk);
    bit [14*NB-1:0] h;
    for (int i = 0; i < 2*NB; i++)
      h[7*i +: 7] = blk[i] ? 7'h7F : glyph(nib[4*i +: 4]);
    return h;
  endfunction

  function automatic vec_t mk(input bit r, input bit m, input bit c, input bit v,
                              input bit [7:0] d, input bit [31:0] nib, input bit [7:0] blk,
                              input bit kd, input bit ext, input bit [7:0] lm, input string name);
    vec_t t;
    t.r = r; t.m = m; t.c = c; t.v = v; t.d = d;
    t.nib = nib; t.blk = blk; t.kd = kd; t.ext = ext; t.lm = lm; t.name = name;
    return t;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (hex_out !== e.hex) begin
      errors++;
      $display("FAIL %s hex_out: got %h want %h", e.name, hex_out, e.hex);
    end
    checks++;
    if (key_down !== e.kd) begin
      errors++;
      $display("FAIL %s key_down: got %b want %b", e.name, key_down, e.kd);
    end
    checks++;
    if (extended !== e.ext) begin
      errors++;
      $display("FAIL %s extended: got %b want %b", e.name, extended, e.ext);
    end
    checks++;
    if (last_make !== e.lm) begin
      errors++;
      $display("FAIL %s last_make: got %h want %h", e.name, last_make, e.lm);
    end
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk);
    reset      = t.r;
    mode       = t.m;
    clear      = t.c;
    byte_valid = t.v;
    byte_data  = t.d;
    e.hex  = exp_hex(t.nib, t.blk);
    e.kd   = t.kd;
    e.ext  = t.ext;
    e.lm   = t.lm;
    e.name = t.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Reset and RAW history
    tbl.push_back(mk(1,0,0,0,8'h00, 32'h0000_0000, 8'hFF, 0,0,8'h00, "reset"));
    tbl.push_back(mk(1,0,0,1,8'h99, 32'h0000_0000, 8'hFF, 0,0,8'h00, "reset_drops_byte"));
    tbl.push_back(mk(0,0,0,1,8'h1C, 32'h0000_001C, 8'hFC, 0,0,8'h00, "raw_1c"));
    tbl.push_back(mk(0,0,0,1,8'h2A, 32'h0000_1C2A, 8'hF0, 0,0,8'h00, "raw_2a"));
    tbl.push_back(mk(0,0,0,1,8'h3B, 32'h001C_2A3B, 8'hC0, 0,0,8'h00, "raw_3b"));
    tbl.push_back(mk(0,0,0,0,8'hFF, 32'h001C_2A3B, 8'hC0, 0,0,8'h00, "raw_idle"));
    tbl.push_back(mk(0,0,0,1,8'h66, 32'h1C2A_3B66, 8'h00, 0,0,8'h00, "raw_full"));
    tbl.push_back(mk(0,0,0,1,8'h44, 32'h2A3B_6644, 8'h00, 0,0,8'h00, "raw_evict_1c"));
    tbl.push_back(mk(0,0,0,1,8'h55, 32'h3B66_4455, 8'h00, 0,0,8'h00, "raw_evict_2a"));
    tbl.push_back(mk(0,0,1,1,8'h77, 32'h0000_0000, 8'hFF, 0,0,8'h00, "clear_drops_byte"));
    tbl.push_back(mk(0,0,0,1,8'hA5, 32'h0000_00A5, 8'hFC, 0,0,8'h00, "raw_after_clear"));
    // KEY mode
    tbl.push_back(mk(0,1,0,1,8'h1C, 32'h0000_0000, 8'hFF, 0,0,8'h00, "mode_change_drops"));
    tbl.push_back(mk(0,1,0,1,8'h1C, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_make_1c"));
    tbl.push_back(mk(0,1,0,1,8'h1C, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_typematic"));
    tbl.push_back(mk(0,1,0,1,8'hF0, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_brk_pending"));
    tbl.push_back(mk(0,1,0,1,8'h1C, 32'h0000_0000, 8'hFF, 0,0,8'h1C, "key_release_1c"));
    tbl.push_back(mk(0,1,0,1,8'hE0, 32'h0000_0000, 8'hFF, 0,0,8'h1C, "key_ext_pending"));
    tbl.push_back(mk(0,1,0,1,8'h75, 32'h0000_E075, 8'hF0, 1,1,8'h75, "key_ext_make_75"));
    tbl.push_back(mk(0,1,0,1,8'hF0, 32'h0000_E075, 8'hF0, 1,1,8'h75, "key_plain_brk"));
    tbl.push_back(mk(0,1,0,1,8'h75, 32'h0000_E075, 8'hF0, 1,1,8'h75, "key_plain_rel_ignored"));
    tbl.push_back(mk(0,1,0,1,8'hE0, 32'h0000_E075, 8'hF0, 1,1,8'h75, "key_ext_brk_e0"));
    tbl.push_back(mk(0,1,0,1,8'hF0, 32'h0000_E075, 8'hF0, 1,1,8'h75, "key_ext_brk_f0"));
    tbl.push_back(mk(0,1,0,1,8'h75, 32'h0000_0000, 8'hFF, 0,1,8'h75, "key_ext_release"));
    tbl.push_back(mk(0,1,0,1,8'h1C, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_make_1c_again"));
    tbl.push_back(mk(0,1,0,1,8'hF0, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_mis_brk"));
    tbl.push_back(mk(0,1,0,1,8'h32, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "key_mismatch_ignored"));
    tbl.push_back(mk(0,1,0,1,8'h32, 32'h0000_0032, 8'hFC, 1,0,8'h32, "key_make_32"));
    tbl.push_back(mk(0,1,0,1,8'hE1, 32'h0000_00E1, 8'hFC, 1,0,8'hE1, "key_e1_plain"));

    foreach (tbl[i]) apply(tbl[i]);

    // Mode toggle in the middle of an E0 prefix
    apply(mk(0,1,0,1,8'hE0, 32'h0000_00E1, 8'hFC, 1,0,8'hE1, "corner_e0"));
    apply(mk(0,0,0,0,8'h00, 32'h0000_0000, 8'hFF, 0,0,8'h00, "corner_mode_off"));
    apply(mk(0,1,0,0,8'h00, 32'h0000_0000, 8'hFF, 0,0,8'h00, "corner_mode_on"));
    apply(mk(0,1,0,1,8'h1C, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "corner_fresh_make"));

    // Clear in the middle of an E0 prefix
    apply(mk(0,1,0,1,8'hE0, 32'h0000_001C, 8'hFC, 1,0,8'h1C, "corner_e0_b"));
    apply(mk(0,1,1,0,8'h00, 32'h0000_0000, 8'hFF, 0,0,8'h00, "corner_clear_mid"));
    apply(mk(0,1,0,1,8'h6B, 32'h0000_006B, 8'hFC, 1,0,8'h6B, "corner_after_clear"));

    // Reset in the middle of an E0 prefix, KEY mode held through reset
    apply(mk(0,1,0,1,8'hE0, 32'h0000_006B, 8'hFC, 1,0,8'h6B, "corner_e0_c"));
    apply(mk(1,1,0,0,8'h00, 32'h0000_0000, 8'hFF, 0,0,8'h00, "corner_reset_mid"));
    apply(mk(0,1,0,1,8'h75, 32'h0000_0075, 8'hFC, 1,0,8'h75, "corner_after_reset"));

    @(negedge clk);
    byte_valid = 1'b0;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
